multicycle_control_unit: RTL

Moore/Mealy FSM that sequences the multicycle MIPS datapath: fetch, decode, execute, memory and write-back. It sits directly upstream of the datapath muxes and drives their selectors. PCSource is the selector of the 3-input next-PC mux: 0 = ALU result (PC+4), 1 = ALUOut (branch target), 2 = jump target. Memory accesses use a ready handshake, and a retired-instruction counter is provided for debug.

---
 rtl/multicycle_control_unit.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: sequences fetch, decode, execute, memory
// and write-back. It drives the datapath mux selectors and enables, and it
// keeps a count of retired instructions for debug.
module multicycle_control_unit #(
    parameter int unsigned COUNT_BITS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            Opcode,
    input  logic                  Zero,
    input  logic                  MemReady,
    output logic                  PCEn,
    output logic [1:0]            PCSource,
    output logic                  IorD,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  MemtoReg,
    output logic                  RegDst,
    output logic                  RegWrite,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ALUOp,
    output logic                  IllegalOp,
    output logic [COUNT_BITS-1:0] InstrCount
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t                r_state;
    state_t                w_next;
    logic                  w_retire;
    logic [COUNT_BITS-1:0] r_count;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Retired-instruction counter, bumped on the edge that returns to FETCH
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + COUNT_BITS'(1);
        end
    end

    assign InstrCount = r_count;

    // Next-state selection and retire detection
    always_comb begin
        w_next   = S_FETCH;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_next = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:        w_next = S_EXEC;
                    OP_LW, OP_SW:    w_next = S_MEMADR;
                    OP_BEQ, OP_BNE:  w_next = S_BRANCH;
                    OP_ADDI, OP_ORI: w_next = S_IMMEX;
                    OP_J:            w_next = S_JUMP;
                    default:         w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (Opcode == OP_LW) begin
                    w_next = S_MEMRD;
                end else if (Opcode == OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEMRD: begin
                w_next = MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_MEMWR: begin
                w_next   = MemReady ? S_FETCH : S_MEMWR;
                w_retire = MemReady;
            end
            S_EXEC: begin
                w_next = S_RWB;
            end
            S_RWB, S_BRANCH, S_IMMWB, S_JUMP: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_IMMEX: begin
                w_next = S_IMMWB;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Output decode from state, with reset masking the write/request strobes
    always_comb begin
        PCEn      = 1'b0;
        PCSource  = 2'b00;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        MemtoReg  = 1'b0;
        RegDst    = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        IllegalOp = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCEn    = MemReady;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                    OP_ADDI, OP_ORI, OP_J: IllegalOp = 1'b0;
                    default:               IllegalOp = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSource = 2'b01;
                PCEn     = (Opcode == OP_BNE) ? ~Zero : Zero;
            end
            S_IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (Opcode == OP_ORI) ? 2'b11 : 2'b00;
            end
            S_IMMWB: begin
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCEn     = 1'b1;
            end
            default: begin
            end
        endcase
        if (!reset) begin
            PCEn     = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
        end
    end

endmodule
